// File: rtl/histogram_engine_if.sv
// Sample stream, host read-out and status signals of the histogram engine.
// The engine takes the slave side; the sample source / host take the master side.
interface histogram_engine_if #(
    parameter int BINS  = 128,
    parameter int CNT_W = 16
);
    localparam int AW    = $clog2(BINS);
    localparam int TOT_W = CNT_W + AW;

    logic             clr_start;
    logic             s_valid;
    logic [AW-1:0]    s_bin;
    logic             s_ready;
    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             busy;
    logic             sat_flag;
    logic [TOT_W-1:0] total;

    modport master (
        output clr_start, s_valid, s_bin, rd_req, rd_addr,
        input  s_ready, rd_valid, rd_data, busy, sat_flag, total
    );

    modport slave (
        input  clr_start, s_valid, s_bin, rd_req, rd_addr,
        output s_ready, rd_valid, rd_data, busy, sat_flag, total
    );
endinterface

// File: rtl/histogram_engine.sv
// Streaming histogram: one sample per cycle into a RAM of saturating bin counters,
// with a clear sweep, host read-out and a saturating running total.
module histogram_engine #(
    parameter int BINS  = 128,
    parameter int CNT_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    histogram_engine_if.slave   bus
);
    localparam int AW    = $clog2(BINS);
    localparam int TOT_W = CNT_W + AW;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [TOT_W-1:0] TOT_MAX    = '1;
    localparam logic [AW:0]      BINS_C     = (AW+1)'(BINS);
    localparam logic [AW-1:0]    SWEEP_LAST = AW'(BINS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           r_state;
    logic [AW-1:0]    r_sweep;
    logic [CNT_W-1:0] r_mem [BINS];
    logic [CNT_W-1:0] r_rdata;
    logic             r_s1_vld;
    logic [AW-1:0]    r_s1_addr;
    logic             r_fwd_vld;
    logic [AW-1:0]    r_fwd_addr;
    logic [CNT_W-1:0] r_fwd_val;
    logic             r_rd_pend;
    logic [AW-1:0]    r_rd_addr;
    logic [CNT_W-1:0] r_rd_hold;
    logic             r_sat;
    logic [TOT_W-1:0] r_total;

    logic             w_run, w_accept, w_host, w_s1_inr, w_we;
    logic [AW-1:0]    w_raddr, w_waddr;
    logic [CNT_W-1:0] w_s1_old, w_s1_new, w_wdata, w_rd_val;

    assign w_run    = (r_state == RUN);
    assign w_accept = bus.s_valid && bus.s_ready;
    assign w_host   = w_run && bus.rd_req;
    // host reads and samples never share a cycle, so one RAM read port serves both
    assign w_raddr  = w_host ? bus.rd_addr : bus.s_bin;

    assign w_s1_inr = r_s1_vld && ({1'b0, r_s1_addr} < BINS_C);
    assign w_s1_old = (r_fwd_vld && r_fwd_addr == r_s1_addr) ? r_fwd_val : r_rdata;
    assign w_s1_new = (w_s1_old == CNT_MAX) ? w_s1_old : w_s1_old + 1'b1;

    // stage 1 is always empty while sweeping: s_ready is low on the cycle that starts a sweep
    assign w_we    = RST && (!w_run || w_s1_inr);
    assign w_waddr = w_run ? r_s1_addr : r_sweep;
    assign w_wdata = w_run ? w_s1_new : '0;

    assign w_rd_val = (r_fwd_vld && r_fwd_addr == r_rd_addr) ? r_fwd_val : r_rdata;

    assign bus.s_ready  = w_run && !bus.rd_req && !bus.clr_start;
    assign bus.busy     = !w_run;
    assign bus.rd_valid = r_rd_pend;
    assign bus.rd_data  = r_rd_pend ? w_rd_val : r_rd_hold;
    assign bus.sat_flag = r_sat;
    assign bus.total    = r_total;

    always_ff @(posedge CLK) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= CLEAR;
            r_sweep    <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_addr  <= '0;
            r_fwd_vld  <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_val  <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_hold  <= '0;
            r_sat      <= 1'b0;
            r_total    <= '0;
        end else begin
            r_s1_vld   <= w_accept;
            r_s1_addr  <= bus.s_bin;
            r_fwd_vld  <= w_we;
            r_fwd_addr <= w_waddr;
            r_fwd_val  <= w_wdata;
            r_rd_pend  <= w_host;
            if (w_host)
                r_rd_addr <= bus.rd_addr;
            if (r_rd_pend)
                r_rd_hold <= w_rd_val;

            case (r_state)
                CLEAR: begin
                    if (bus.clr_start)
                        r_sweep <= '0;
                    else if (r_sweep == SWEEP_LAST) begin
                        r_sweep <= '0;
                        r_state <= RUN;
                    end else
                        r_sweep <= r_sweep + 1'b1;
                end
                RUN: begin
                    if (bus.clr_start) begin
                        r_sweep <= '0;
                        r_state <= CLEAR;
                    end
                end
                default: r_state <= CLEAR;
            endcase

            if (bus.clr_start) begin
                r_sat   <= 1'b0;
                r_total <= '0;
            end else begin
                if (w_s1_inr && w_s1_old == CNT_MAX)
                    r_sat <= 1'b1;
                if (w_accept && r_total != TOT_MAX)
                    r_total <= r_total + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: 12 bins of 4-bit counters so saturation, out-of-range
// bins and total saturation are all reachable; model is plain per-bin arithmetic.
module tb_histogram_engine;
    localparam int BINS  = 12;
    localparam int CNT_W = 4;
    localparam int AW    = $clog2(BINS);
    localparam int TOT_W = CNT_W + AW;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int TMAX  = (1 << TOT_W) - 1;

    logic CLK;
    logic RST;

    histogram_engine_if #(.BINS(BINS), .CNT_W(CNT_W)) bus();
    histogram_engine #(.BINS(BINS), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    // reference model
    int m_bin [BINS];
    int m_total;
    bit m_sat;
    int tot_before;

    // outputs captured at the falling edge of the most recent step
    logic             ob_ready, ob_busy, ob_rv, ob_sat;
    logic [CNT_W-1:0] ob_rd;
    logic [TOT_W-1:0] ob_tot;

    typedef struct {
        int bin;
        int n;
        int exp_cnt;   // -1: bin out of range, no read-back
        int exp_tot;
        bit exp_sat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int b = 0; b < BINS; b++) m_bin[b] = 0;
        m_total = 0;
        m_sat = 1'b0;
    endfunction

    function automatic void model_accept(input int bin);
        if (bin < BINS) begin
            if (m_bin[bin] == CMAX) m_sat = 1'b1;
            else m_bin[bin]++;
        end
        if (m_total < TMAX) m_total++;
    endfunction

    // one clock cycle: drive, sample at negedge, update model, return just after posedge
    task automatic step(input bit vld, input int bin, input bit rq, input int ra, input bit clr);
        bus.s_valid   = vld;
        bus.s_bin     = AW'(bin);
        bus.rd_req    = rq;
        bus.rd_addr   = AW'(ra);
        bus.clr_start = clr;
        @(negedge CLK);
        ob_ready = bus.s_ready;
        ob_busy  = bus.busy;
        ob_rv    = bus.rd_valid;
        ob_rd    = bus.rd_data;
        ob_tot   = bus.total;
        ob_sat   = bus.sat_flag;
        tot_before = m_total;
        if (vld && ob_ready === 1'b1) model_accept(bin);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic read_bin(input int a, input int exp, input string name);
        step(1'b0, 0, 1'b1, a, 1'b0);
        idle();
        check({name, "_rd_valid"}, 32'(ob_rv), 32'd1);
        check(name, 32'(ob_rd), 32'(exp));
    endtask

    // counts busy cycles from now; noise drives samples and reads that must be ignored
    task automatic count_busy(input bit noise, output int n, output int bad);
        bit nz;
        n = 0;
        bad = 0;
        for (int i = 0; i < BINS + 20; i++) begin
            nz = noise && (i < BINS - 1);
            step(nz, int'($urandom_range(0, 15)), nz, int'($urandom_range(0, BINS - 1)), 1'b0);
            if (ob_busy !== 1'b1) break;
            n++;
            if (ob_ready !== 1'b0 || ob_rv !== 1'b0) bad++;
        end
    endtask

    task automatic do_clear(input string name);
        int n, bad;
        step(1'b1, 2, 1'b0, 0, 1'b1);
        check({name, "_ready_on_clr"}, 32'(ob_ready), 32'd0);
        model_clear();
        count_busy(1'b1, n, bad);
        check({name, "_busy_cycles"}, 32'(n), 32'(BINS));
        check({name, "_ignored_io"}, 32'(bad), 32'd0);
        check({name, "_total"}, 32'(ob_tot), 32'd0);
        check({name, "_sat"}, 32'(ob_sat), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int n, bad, acc, c, exp_mid, pend, pend_exp, snap;
        int q[$];
        bit vld, rq;
        int bin, ra;

        vecs[0] = '{5, 10, 10, 10, 1'b0};
        vecs[1] = '{7, 3, 3, 13, 1'b0};
        vecs[2] = '{5, 2, 12, 15, 1'b0};
        vecs[3] = '{0, 20, 15, 35, 1'b1};
        vecs[4] = '{13, 4, -1, 39, 1'b1};
        vecs[5] = '{11, 1, 1, 40, 1'b1};
        vecs[6] = '{5, 5, 15, 45, 1'b1};

        bus.s_valid = 1'b0; bus.s_bin = '0; bus.rd_req = 1'b0;
        bus.rd_addr = '0; bus.clr_start = 1'b0;
        RST = 1'b0;
        model_clear();
        @(posedge CLK); #1;
        repeat (3) step(1'b1, 3, 1'b1, 3, 1'b0);
        check("rst_s_ready", 32'(ob_ready), 32'd0);
        check("rst_busy", 32'(ob_busy), 32'd1);
        check("rst_rd_valid", 32'(ob_rv), 32'd0);
        check("rst_rd_data", 32'(ob_rd), 32'd0);
        check("rst_sat_flag", 32'(ob_sat), 32'd0);
        check("rst_total", 32'(ob_tot), 32'd0);

        RST = 1'b1;
        count_busy(1'b1, n, bad);
        check("init_busy_cycles", 32'(n), 32'(BINS));
        check("init_ignored_io", 32'(bad), 32'd0);
        for (int b = 0; b < BINS; b++) read_bin(b, 0, "init_bin_zero");

        // table: back-to-back bursts, each read back on the very next cycle
        for (int v = 0; v < 7; v++) begin
            acc = 0;
            for (int k = 0; k < vecs[v].n; k++) begin
                step(1'b1, vecs[v].bin, 1'b0, 0, 1'b0);
                if (ob_ready === 1'b1) acc++;
            end
            check("vec_accepted", 32'(acc), 32'(vecs[v].n));
            if (vecs[v].exp_cnt >= 0) read_bin(vecs[v].bin, vecs[v].exp_cnt, "vec_bin_count");
            else begin idle(); idle(); end
            check("vec_total", 32'(ob_tot), 32'(vecs[v].exp_tot));
            check("vec_sat_flag", 32'(ob_sat), 32'(vecs[v].exp_sat));
        end

        // alternating 3/4 with a host read of bin 3 in the middle of the stream
        do_clear("clr1");
        q = '{3, 4, 3, 4, 3, 4, 3, 4};
        bad = 0;
        c = 0;
        while (q.size() > 0 && c < 20) begin
            step(1'b1, q[0], c == 3, 3, 1'b0);
            if (c == 3) check("alt_ready_low_on_rd", 32'(ob_ready), 32'd0);
            else if (ob_ready !== 1'b1) bad++;
            if (c == 4) begin
                check("alt_mid_rd_valid", 32'(ob_rv), 32'd1);
                check("alt_mid_rd_data", 32'(ob_rd), 32'd2);
            end
            if (ob_ready === 1'b1) void'(q.pop_front());
            c++;
        end
        check("alt_ready_elsewhere", 32'(bad), 32'd0);
        idle();
        read_bin(3, 4, "alt_bin3");
        read_bin(4, 4, "alt_bin4");
        check("alt_total", 32'(ob_tot), 32'd8);

        // random stream with interleaved reads; long enough to saturate total
        do_clear("clr2");
        pend = 0;
        pend_exp = 0;
        for (int i = 0; i < 500; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            bin = int'($urandom_range(0, 15));
            rq  = ($urandom_range(0, 4) == 0);
            ra  = int'($urandom_range(0, BINS - 1));
            snap = m_bin[ra];
            step(vld, bin, rq, ra, 1'b0);
            check("rnd_ready", 32'(ob_ready), 32'(!rq));
            check("rnd_total", 32'(ob_tot), 32'(tot_before));
            if (pend != 0) check("rnd_rd_data", 32'(ob_rd), 32'(pend_exp));
            check("rnd_rd_valid", 32'(ob_rv), 32'(pend));
            pend = rq;
            pend_exp = snap;
        end
        idle();
        if (pend != 0) check("rnd_rd_data", 32'(ob_rd), 32'(pend_exp));
        check("rnd_rd_valid", 32'(ob_rv), 32'(pend));
        idle();
        check("rnd_total_final", 32'(ob_tot), 32'(m_total));
        check("rnd_total_saturated", 32'(ob_tot), 32'(TMAX));
        check("rnd_sat_flag", 32'(ob_sat), 32'(m_sat));
        for (int b = 0; b < BINS; b++) read_bin(b, m_bin[b], "rnd_bin");

        do_clear("clr3");
        for (int b = 0; b < BINS; b++) read_bin(b, 0, "clr3_bin_zero");

        // reset mid-sweep, with a sample in flight when the sweep began
        step(1'b1, 6, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        model_clear();
        repeat (5) idle();
        RST = 1'b0;
        repeat (2) idle();
        check("midrst_busy", 32'(ob_busy), 32'd1);
        check("midrst_total", 32'(ob_tot), 32'd0);
        RST = 1'b1;
        count_busy(1'b0, n, bad);
        check("midrst_busy_cycles", 32'(n), 32'(BINS));
        read_bin(6, 0, "midrst_bin6");
        read_bin(0, 0, "midrst_bin0");
        step(1'b1, 6, 1'b0, 0, 1'b0);
        read_bin(6, 1, "midrst_bin6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/histogram_engine.md
# histogram_engine

Parametrised single-clock histogram accumulator for streamed sample values. Each accepted sample increments a per-bin counter held in an inferred synchronous RAM, sustaining one sample per cycle with read-modify-write forwarding. Adds a hardware clear sweep, saturating counters, a host read-out port and a running sample total. Sits between the sample source (ADC/generator stream) and the readout/display logic; no PLL or derived clocks.

## Interface
- BINS, 128, number of histogram bins (power of two not required, >=2)
- CNT_W, 16, width of each bin counter
- AW, $clog2(BINS), bin address width (derived, not overridden)
- TOT_W, CNT_W+AW, width of sample total
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-low
- clr_start  in  1  pulse: start clear sweep
- s_valid  in  1  sample valid
- s_bin  in  AW  sample bin index
- s_ready  out  1  sample accepted when s_valid && s_ready
- rd_req  in  1  host read request
- rd_addr  in  AW  host read bin
- rd_valid  out  1  rd_data valid pulse
- rd_data  out  CNT_W  bin count
- busy  out  1  clear sweep in progress
- sat_flag  out  1  sticky: some bin hit saturation
- total  out  TOT_W  accepted-sample count, saturating

## Operation
- FSM states: CLEAR, RUN. RST=0 forces CLEAR with sweep address 0; exit of reset starts a full sweep (memory content after power-up is never trusted).
- CLEAR: writes 0 to bin k in sweep cycle k, k=0..BINS-1; then RUN. busy=1, s_ready=0, rd_req ignored (no rd_valid). clr_start during CLEAR restarts sweep at address 0.
- RUN: clr_start -> CLEAR next cycle; any sample in the update pipeline still completes its write before the sweep overwrites its bin. Sweep start clears sat_flag and total.
- s_ready = (state==RUN) && !rd_req && !clr_start. Host read has priority over samples.
- Update pipeline: stage 0 (accept cycle) issues RAM read of s_bin; stage 1 receives data, computes new = (old == 2^CNT_W-1) ? old : old+1, writes it to RAM.
- Forwarding: one-entry register holds last written (addr, value). If stage-1 addr equals the previous cycle's write addr, stage 1 uses forwarded value instead of RAM data. Same forwarding applies to host reads.
- Saturation: bin at max stays at max; sat_flag set the cycle such a saturating increment is written. total increments per accepted sample, holds at 2^TOT_W-1.
- s_bin >= BINS (non-power-of-two BINS): sample accepted, counted in total, bin not modified.

## Timing
- Reset values: s_ready 0, busy 1, rd_valid 0, rd_data 0, sat_flag 0, total 0.
- First cycle with RST=1 is sweep cycle 0; busy high for BINS cycles; s_ready may rise in cycle BINS.
- Throughput 1 sample/cycle, including back-to-back identical bins.
- Sample accepted at cycle t: RAM updated end of t+1; visible to a host read issued at t+1 or later.
- rd_req at cycle t (RUN): rd_valid=1 and rd_data valid at t+1 for one cycle; rd_data holds value until next read.
- total updates the cycle after acceptance.
- RST low mid-sweep or mid-update: pipeline flushed, sweep restarts from 0.

## Test plan
- Reset release -> busy high exactly BINS cycles, s_ready=0 throughout, all bins read back 0 afterwards.
- 10 back-to-back samples to bin 5, then rd_addr=5 -> rd_data=10, total=10 (forwarding check).
- Alternating bins 3,4,3,4 (8 samples) plus one rd_req on bin 3 mid-stream -> s_ready low that cycle only, final reads 3->4, 4->4, total=8.
- CNT_W=4, 20 samples to bin 0 -> bin 0 reads 15, sat_flag=1, total=20.
- clr_start after 50 random samples -> busy BINS cycles, all bins 0, total=0, sat_flag=0.
- RST pulsed low mid-sweep -> sweep restarts at 0, busy extends to BINS cycles from release.
